// File: rtl/iq_deserializer.sv
// rtl/iq_deserializer.sv - serial I/Q word framer with sign-extending decode and show-ahead sample FIFO
module iq_deserializer #(
    parameter int FIFO_AW    = 4,
    parameter int LOCK_WORDS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_bit,
    input  logic        rx_bit_valid,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        rd_dr,
    output logic        locked,
    output logic        sync_err,
    output logic [15:0] ovf_count
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int GW    = (LOCK_WORDS < 1) ? 1 : $clog2(LOCK_WORDS + 1);
    localparam logic [GW-1:0] LOCK_MAX = GW'(LOCK_WORDS);

    typedef enum logic {HUNT, FRAMED} state_t;

    state_t             state;
    logic [31:0]        sr;
    logic [31:0]        next_word;
    logic [4:0]         bit_cnt;
    logic [GW-1:0]      good_cnt;
    logic [GW-1:0]      good_inc;
    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW:0]   wp;
    logic [FIFO_AW:0]   rp;
    logic               sync_ok;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               wr;
    logic [31:0]        push_data;
    logic               unused_bits;

    assign next_word = {sr[30:0], rx_bit};
    assign sync_ok   = (next_word[31:30] == 2'b10) && (next_word[15:14] == 2'b01);
    assign good_inc  = (good_cnt == LOCK_MAX) ? LOCK_MAX : good_cnt + GW'(1);

    // A word completes on any matching bit while hunting, or on every 32nd bit once framed.
    assign push = rx_bit_valid && sync_ok && ((state == HUNT) || (bit_cnt == 5'd31));

    assign push_data = {{3{next_word[29]}}, next_word[29:17],
                        {3{next_word[13]}}, next_word[13:1]};

    assign empty = (wp == rp);
    assign full  = ((wp ^ rp) == {1'b1, {FIFO_AW{1'b0}}});
    assign pop   = rd_en && !empty;
    // When full, a simultaneous pop frees the head slot, which is the slot being written.
    assign wr    = push && (!full || pop);

    assign rd_data = mem[rp[FIFO_AW-1:0]];
    assign rd_dr   = !empty;
    assign locked  = (state == FRAMED) && (good_cnt == LOCK_MAX);

    assign unused_bits = ^{sr[31], next_word[16], next_word[0]};

    always_ff @(posedge clk) begin
        if (!rst && wr) begin
            mem[wp[FIFO_AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            sr        <= '0;
            bit_cnt   <= '0;
            good_cnt  <= '0;
            sync_err  <= 1'b0;
            wp        <= '0;
            rp        <= '0;
            ovf_count <= '0;
        end else begin
            sync_err <= 1'b0;
            if (rx_bit_valid) begin
                sr <= next_word;
                case (state)
                    HUNT: begin
                        if (sync_ok) begin
                            bit_cnt  <= '0;
                            good_cnt <= good_inc;
                            state    <= FRAMED;
                        end
                    end
                    FRAMED: begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd31) begin
                            if (sync_ok) begin
                                good_cnt <= good_inc;
                            end else begin
                                good_cnt <= '0;
                                sync_err <= 1'b1;
                                state    <= HUNT;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
            if (wr) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            if (push && full && !pop && (ovf_count != 16'hFFFF)) begin
                ovf_count <= ovf_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_iq_deserializer.sv
// tb/tb_iq_deserializer.sv - directed self-checking bench for iq_deserializer
module tb_iq_deserializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_bit;
    logic        rx_bit_valid;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_dr;
    logic        locked;
    logic        sync_err;
    logic [15:0] ovf_count;

    int checks   = 0;
    int failures = 0;
    int gap_max  = 0;

    localparam logic [31:0] W_A   = 32'h82467E00;
    localparam logic [31:0] E_A   = 32'h0123FF00;
    localparam logic [31:0] W_BAD = 32'hC2467E00;

    logic [31:0] gap_words [3] = '{32'hBFFF4002, 32'hA0005FFF, 32'h95786AAB};
    logic [31:0] gap_exp   [3] = '{32'hFFFF0001, 32'hF0000FFF, 32'h0ABCF555};

    iq_deserializer #(.FIFO_AW(4), .LOCK_WORDS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_bit       (rx_bit),
        .rx_bit_valid (rx_bit_valid),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_dr        (rd_dr),
        .locked       (locked),
        .sync_err     (sync_err),
        .ovf_count    (ovf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_bit_valid = 1'b0;
        rd_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        if (gap_max > 0) begin
            repeat ($urandom_range(0, gap_max)) begin
                rx_bit_valid = 1'b0;
                rx_bit = 1'($urandom);
                tick();
            end
        end
        rx_bit = b;
        rx_bit_valid = 1'b1;
        tick();
        rx_bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 31; b >= 0; b--) send_bit(w[b]);
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    function automatic logic [31:0] make_word(input logic [12:0] i, input logic [12:0] q);
        return {2'b10, i, 1'b1, 2'b01, q, 1'b0};
    endfunction

    initial begin
        logic [31:0] w;
        rst = 1'b1;
        rx_bit = 1'b0;
        rx_bit_valid = 1'b0;
        rd_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("reset_rd_dr", 32'(rd_dr), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_sync_err", 32'(sync_err), 32'd0);
        check("reset_ovf", 32'(ovf_count), 32'd0);

        // pops on an empty FIFO must not move the read pointer
        rd_en = 1'b1;
        tick();
        tick();
        rd_en = 1'b0;
        check("empty_pop_rd_dr", 32'(rd_dr), 32'd0);

        send_word(W_A);
        check("first_rd_dr", 32'(rd_dr), 32'd1);
        check("first_rd_data", rd_data, E_A);
        check("first_locked", 32'(locked), 32'd0);
        pop_one();
        check("first_drained", 32'(rd_dr), 32'd0);

        // three back-to-back words, lock after the second
        do_reset();
        send_word(W_A);
        check("lock_after_1", 32'(locked), 32'd0);
        send_word(W_A);
        check("lock_after_2", 32'(locked), 32'd1);
        send_word(W_A);
        check("lock_after_3", 32'(locked), 32'd1);
        rd_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("burst_rd_dr_%0d", k), 32'(rd_dr), 32'd1);
            check($sformatf("burst_data_%0d", k), rd_data, E_A);
            tick();
        end
        rd_en = 1'b0;
        check("burst_empty", 32'(rd_dr), 32'd0);

        send_word(W_BAD);
        check("bad_sync_err", 32'(sync_err), 32'd1);
        check("bad_locked", 32'(locked), 32'd0);
        check("bad_no_push", 32'(rd_dr), 32'd0);
        tick();
        check("bad_sync_err_pulse", 32'(sync_err), 32'd0);
        send_word(W_A);
        check("recover_rd_dr", 32'(rd_dr), 32'd1);
        check("recover_data", rd_data, E_A);
        check("recover_locked", 32'(locked), 32'd0);
        check("recover_sync_err", 32'(sync_err), 32'd0);

        // misaligned prefix plus random valid gaps
        do_reset();
        gap_max = 3;
        w = 32'h0000003F;
        for (int b = 6; b >= 0; b--) send_bit(w[b]);
        for (int k = 0; k < 3; k++) send_word(gap_words[k]);
        gap_max = 0;
        check("gap_locked", 32'(locked), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("gap_rd_dr_%0d", k), 32'(rd_dr), 32'd1);
            check($sformatf("gap_data_%0d", k), rd_data, gap_exp[k]);
            pop_one();
        end
        check("gap_empty", 32'(rd_dr), 32'd0);

        // overflow: 18 pushes into a 16-deep FIFO, then push+pop while full
        do_reset();
        for (int n = 1; n <= 18; n++) send_word(make_word(13'(n), 13'(-n)));
        check("ovf_count_2", 32'(ovf_count), 32'd2);
        check("ovf_rd_dr", 32'(rd_dr), 32'd1);
        check("ovf_head", rd_data, {16'd1, 16'hFFFF});
        w = make_word(13'd19, 13'(-19));
        for (int b = 31; b >= 1; b--) send_bit(w[b]);
        rx_bit = w[0];
        rx_bit_valid = 1'b1;
        rd_en = 1'b1;
        tick();
        rx_bit_valid = 1'b0;
        rd_en = 1'b0;
        check("full_pushpop_ovf", 32'(ovf_count), 32'd2);
        for (int k = 0; k < 16; k++) begin
            int n;
            n = (k < 15) ? k + 2 : 19;
            check($sformatf("ovf_rd_dr_%0d", k), 32'(rd_dr), 32'd1);
            check($sformatf("ovf_data_%0d", k), rd_data, {16'(n), 16'(-n)});
            pop_one();
        end
        check("ovf_drained", 32'(rd_dr), 32'd0);

        // reset in the middle of a word with data queued
        do_reset();
        for (int k = 0; k < 3; k++) send_word(W_A);
        for (int b = 31; b >= 12; b--) send_bit(W_A[b]);
        rst = 1'b1;
        rx_bit = 1'b1;
        rx_bit_valid = 1'b1;
        rd_en = 1'b1;
        tick();
        rst = 1'b0;
        rx_bit_valid = 1'b0;
        rd_en = 1'b0;
        check("midrst_rd_dr", 32'(rd_dr), 32'd0);
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_ovf", 32'(ovf_count), 32'd0);
        send_word(W_A);
        check("midrst_push_rd_dr", 32'(rd_dr), 32'd1);
        check("midrst_push_data", rd_data, E_A);
        check("midrst_push_locked", 32'(locked), 32'd0);
        pop_one();
        check("midrst_single", 32'(rd_dr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
